seq_add_requester: RTL and testbench
====================================

# seq_add_requester

Initiator-side controller for the team's 32-bit multi-cycle adder (`sequential_adder`). It accepts operand pairs on a valid/ready input stream and issues each pair to the adder with a one-cycle `start` pulse. It waits for the adder's one-cycle `ready` pulse, captures the result and overflow, and holds them on a valid/ready output stream until consumed. A watchdog flags an adder that never completes.

## Interface
Parameters:
- TIMEOUT, default 8: number of WAIT cycles allowed before an error is declared. Must be ≥ 6.

Ports:
- clk  in  1  clock; all state changes on posedge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair
- in_a  in  32  operand A
- in_b  in  32  operand B
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_res  out  32  captured sum
- out_ovf  out  1  captured carry-out
- add_start  out  1  start pulse to adder
- add_a  out  32  operand A to adder
- add_b  out  32  operand B to adder
- add_res  in  32  adder result
- add_ovf  in  1  adder overflow
- add_ready  in  1  adder completion pulse, one cycle wide
- err  out  1  sticky timeout flag
- err_clr  in  1  clears err

## Operation
- States: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_a/in_b into the operand registers and go to ISSUE.
- ISSUE:
  - add_start=1 for exactly this cycle.
  - Go to WAIT; clear the watchdog counter.
- WAIT:
  - The watchdog counter increments each cycle.
  - If add_ready: capture add_res→out_res and add_ovf→out_ovf, then go to HOLD.
  - Else, if counter == TIMEOUT-1: set err, drop the operation, go to IDLE.
  - add_ready in the same cycle as the timeout condition: add_ready wins (capture, no err).
- HOLD:
  - out_valid=1.
  - On out_ready: go to IDLE.
  - out_res/out_ovf stay stable while out_valid=1 and out_ready=0.
- add_a/add_b are driven continuously from the operand registers; they change only on input acceptance.
- add_ready outside WAIT is ignored.
- err:
  - Set by timeout; cleared by err_clr or rst.
  - A timeout and err_clr in the same cycle: err stays 1 (set wins).
- Sum width is exactly 32 bits; the carry is reported only via out_ovf. No arithmetic is done in this block.
- rst mid-operation: return to IDLE next edge and discard any operation in flight, with no output. The adder shares rst, so both ends realign.

## Timing
- Reset values:
  - state=IDLE
  - in_ready=1
  - out_valid=0, out_res=0, out_ovf=0
  - add_start=0, add_a=0, add_b=0
  - err=0
- Accept in cycle n (in_valid & in_ready) → add_start in n+1.
- With the adder at nominal latency, add_ready arrives in n+6 (5th WAIT cycle, counter=4) → out_valid in n+7.
- With out_ready held high, out_valid lasts one cycle and in_ready returns in n+8. Peak throughput is 1 operation / 8 cycles.
- in_ready is 0 in ISSUE, WAIT and HOLD; there is no input buffering.
- add_start is never asserted while the adder is busy; a new start cannot occur before the cycle after add_ready.

## Structure
- Package seq_add_pkg contains:
  - state enum req_state_t {IDLE, ISSUE, WAIT, HOLD}
  - localparam ADD_LATENCY=5 (nominal WAIT cycles), used in assertions
- The existing `register` module is instantiated for the operand registers (two, width 32) and the result register (width 33: {ovf, res}).
- The watchdog is a local counter of $clog2(TIMEOUT) bits; no new sub-module.

## Test plan
- Basic sum: connect `sequential_adder`, send a=0x0000_00FF, b=0x0000_0001 → out_res=0x0000_0100, out_ovf=0, out_valid exactly 7 cycles after acceptance.
- Overflow and carry chain: a=0xFFFF_FFFF, b=0x0000_0001 → out_res=0x0000_0000, out_ovf=1. Then a=0x7F7F_7F7F, b=0x0101_0101 → 0x8080_8080, out_ovf=0.
- Back-pressure: hold out_ready=0 for 10 cycles → out_valid stays 1, out_res stable, in_ready=0, add_start never reasserted. Then release → in_ready=1 next cycle.
- Streaming: 4 back-to-back pairs with out_ready=1 → 4 correct results, accepts exactly 8 cycles apart, one add_start per operation.
- Timeout: stub adder never asserts add_ready, TIMEOUT=8 → err=1 at the 8th WAIT cycle, state back to IDLE, out_valid never asserted. Then err_clr → err=0.
- Reset mid-op: assert rst in the 3rd WAIT cycle → next cycle in_ready=1 and out_valid=0. A following pair 0x10+0x20 → out_res=0x30.

Source files
------------

// File: rtl/seq_add_pkg.sv
// Shared types and constants for the sequential-adder requester.
package seq_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } req_state_t;

  // Nominal number of WAIT cycles before the adder answers.
  localparam int ADD_LATENCY = 5;

  localparam int DATA_W = 32;

endpackage

// File: rtl/register.sv
// Generic load-enabled register with synchronous active-high clear.
module register #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  // Load on enable, clear on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_q <= '0;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/seq_add_requester.sv
// Initiator-side controller for the multi-cycle 32-bit adder.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | ready for a new operand pair
// ISSUE | one-cycle start pulse to the adder
// WAIT  | waiting for the adder's ready pulse, watchdog running
// HOLD  | result presented downstream until consumed
module seq_add_requester
  import seq_add_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_res,
  output logic              out_ovf,
  output logic              add_start,
  output logic [DATA_W-1:0] add_a,
  output logic [DATA_W-1:0] add_b,
  input  logic [DATA_W-1:0] add_res,
  input  logic              add_ovf,
  input  logic              add_ready,
  output logic              err,
  input  logic              err_clr
);

  localparam int                CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(TIMEOUT - 1);

  req_state_t        r_state;
  logic [CNT_W-1:0]  r_wdog;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_add_start;
  logic              r_err;

  logic              w_accept;
  logic              w_capture;
  logic              w_timeout;
  logic [DATA_W:0]   w_res_q;

  assign w_accept  = (r_state == IDLE) && in_valid;
  // add_ready has priority over the watchdog in the same cycle.
  assign w_capture = (r_state == WAIT) && add_ready;
  assign w_timeout = (r_state == WAIT) && !add_ready && (r_wdog == LAST_CNT);

  register #(.W(DATA_W)) u_reg_a (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_accept),
    .i_d  (in_a),
    .o_q  (add_a)
  );

  register #(.W(DATA_W)) u_reg_b (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_accept),
    .i_d  (in_b),
    .o_q  (add_b)
  );

  register #(.W(DATA_W + 1)) u_reg_res (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_capture),
    .i_d  ({add_ovf, add_res}),
    .o_q  (w_res_q)
  );

  assign out_ovf   = w_res_q[DATA_W];
  assign out_res   = w_res_q[DATA_W-1:0];
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign add_start = r_add_start;
  assign err       = r_err;

  // Request sequencing, watchdog and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wdog      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_add_start <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // Set beats clear when both happen together.
      if (w_timeout) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_state     <= ISSUE;
            r_in_ready  <= 1'b0;
            r_add_start <= 1'b1;
          end
        end
        ISSUE: begin
          r_add_start <= 1'b0;
          r_wdog      <= '0;
          r_state     <= WAIT;
        end
        WAIT: begin
          if (add_ready) begin
            r_state     <= HOLD;
            r_out_valid <= 1'b1;
          end else if (r_wdog == LAST_CNT) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b1;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // The start pulse only ever appears in ISSUE, so the adder is never restarted while busy.
  a_start_in_issue : assert property (@(posedge clk) disable iff (rst)
    r_add_start |-> (r_state == ISSUE));

  // The watchdog must never expire before the adder's nominal latency has elapsed.
  a_timeout_after_nominal : assert property (@(posedge clk) disable iff (rst)
    w_timeout |-> (int'(r_wdog) >= ADD_LATENCY));

endmodule

// File: tb/tb_seq_add_requester.sv
module tb_seq_add_requester;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic        out_ovf;
  logic        add_start;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_res;
  logic        add_ovf;
  logic        add_ready;
  logic        err;
  logic        err_clr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_add_requester #(.TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_ovf   (out_ovf),
    .add_start (add_start),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_res   (add_res),
    .add_ovf   (add_ovf),
    .add_ready (add_ready),
    .err       (err),
    .err_clr   (err_clr)
  );

  // Behavioural adder: answers lat_cfg cycles after the start pulse.
  int          lat_cfg = 5;
  bit          never_resp = 1'b0;
  bit          spur = 1'b0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  int          m_cnt = 0;
  bit          m_busy = 1'b0;
  int          start_cnt = 0;
  int          overlap_cnt = 0;

  assign {add_ovf, add_res} = {1'b0, m_a} + {1'b0, m_b};

  always @(posedge clk) begin
    if (rst) begin
      add_ready <= 1'b0;
      m_busy    <= 1'b0;
      m_cnt     <= 0;
    end else begin
      add_ready <= spur;
      if (add_start) begin
        start_cnt <= start_cnt + 1;
        if (m_busy) overlap_cnt <= overlap_cnt + 1;
        m_a   <= add_a;
        m_b   <= add_b;
        m_cnt <= 1;
        if (never_resp) begin
          m_busy <= 1'b0;
        end else if (lat_cfg == 1) begin
          add_ready <= 1'b1;
          m_busy    <= 1'b0;
        end else begin
          m_busy <= 1'b1;
        end
      end else if (m_busy) begin
        if (m_cnt == lat_cfg - 1) begin
          add_ready <= 1'b1;
          m_busy    <= 1'b0;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation: result expected lat+2 cycles after acceptance, then held for 'hold' extra cycles.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int lat,
                        input int hold, output int acc_cyc);
    logic [32:0] exp;
    int k;
    int s0;
    bit seen;
    exp       = {1'b0, a} + {1'b0, b};
    lat_cfg   = lat;
    s0        = start_cnt;
    out_ready = (hold == 0);
    check("in_ready_before_accept", in_ready, 1);
    acc_cyc  = cyc;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    check("add_start_in_issue", add_start, 1);
    check("add_a_issue", add_a, a);
    check("add_b_issue", add_b, b);
    check("in_ready_busy", in_ready, 0);
    k    = 1;
    seen = 1'b0;
    while (k < 30 && !seen) begin
      @(negedge clk);
      k++;
      if (out_valid) seen = 1'b1;
    end
    check("out_valid_latency", k, lat + 2);
    if (seen) begin
      check("out_res", out_res, exp[31:0]);
      check("out_ovf", out_ovf, exp[32]);
      check("add_a_stable", add_a, a);
      check("add_b_stable", add_b, b);
      check("err_clear_on_op", err, 0);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_out_valid", out_valid, 1);
        check("hold_out_res", out_res, exp[31:0]);
        check("hold_out_ovf", out_ovf, exp[32]);
        check("hold_in_ready", in_ready, 0);
        check("hold_add_start", add_start, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("in_ready_after_consume", in_ready, 1);
      check("out_valid_after_consume", out_valid, 0);
      check("starts_per_op", start_cnt - s0, 1);
    end
  endtask

  // Adder never answers: error after the 8th WAIT cycle, optionally with err_clr in that same cycle.
  task automatic run_timeout(input bit clr_same);
    bit ov_seen;
    never_resp = 1'b1;
    out_ready  = 1'b1;
    ov_seen    = 1'b0;
    check("to_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_a     = $urandom;
    in_b     = $urandom;
    @(negedge clk);
    in_valid = 1'b0;
    check("to_add_start", add_start, 1);
    for (int k = 2; k <= 9; k++) begin
      @(negedge clk);
      if (out_valid) ov_seen = 1'b1;
      check("to_err_before", err, 0);
      check("to_in_ready_wait", in_ready, 0);
    end
    err_clr = clr_same;
    @(negedge clk);
    err_clr = 1'b0;
    if (out_valid) ov_seen = 1'b1;
    check("to_err_set", err, 1);
    check("to_back_idle", in_ready, 1);
    @(negedge clk);
    check("to_err_sticky", err, 1);
    check("to_no_out_valid", ov_seen, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("to_err_cleared", err, 0);
    never_resp = 1'b0;
  endtask

  initial begin
    int t0;
    int t1;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] last_res;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_res", out_res, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_add_start", add_start, 0);
    check("rst_add_a", add_a, 0);
    check("rst_add_b", add_b, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic sum and overflow / carry chain
    run_op(32'h0000_00FF, 32'h0000_0001, 5, 0, t0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 5, 0, t0);
    run_op(32'h7F7F_7F7F, 32'h0101_0101, 5, 0, t0);

    // Back-pressure for 10 cycles
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 5, 10, t0);

    // Streaming: accepts exactly 8 cycles apart
    run_op(32'h0000_0001, 32'h0000_0002, 5, 0, t0);
    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_op(ra, rb, 5, 0, t1);
      check("stream_spacing", t1 - t0, 8);
      t0 = t1;
    end

    // add_ready outside WAIT is ignored
    last_res = out_res;
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    check("spur_out_valid", out_valid, 0);
    check("spur_in_ready", in_ready, 1);
    check("spur_out_res", out_res, last_res);

    // add_ready in the same cycle as the timeout condition: capture wins
    run_op(32'hCAFE_0000, 32'h0000_BABE, 8, 0, t0);

    // Timeouts, without and with a simultaneous err_clr
    run_timeout(1'b0);
    run_timeout(1'b1);

    // Reset in the 3rd WAIT cycle
    lat_cfg  = 5;
    in_valid = 1'b1;
    in_a     = 32'hAAAA_AAAA;
    in_b     = 32'h5555_5555;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_in_ready", in_ready, 1);
    check("rstmid_out_valid", out_valid, 0);
    repeat (6) @(negedge clk);
    check("rstmid_no_late_result", out_valid, 0);
    run_op(32'h0000_0010, 32'h0000_0020, 5, 0, t0);

    // Randomized operations with random latency and back-pressure
    for (int i = 0; i < 10; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      rb = $urandom;
      run_op(ra, rb, $urandom_range(1, 8), $urandom_range(0, 3), t0);
    end

    check("no_start_while_busy", overlap_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
